// File: rtl/space_invaders_pkg.sv
// Shared widths and state encoding for the alien formation sequencer.
package space_invaders_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    CLEARED = 2'd2,
    LANDED  = 2'd3
  } formation_state_t;

endpackage

// File: rtl/formation_extent.sv
// Reduces the alive mask to the outermost living columns, the lowest living row
// and an any-alive flag, using combinational priority encoders.
module formation_extent #(
  parameter int COLS = 11,
  parameter int ROWS = 5,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic [ROWS*COLS-1:0] alive,
  output logic [CW-1:0]        leftcol,
  output logic [CW-1:0]        rightcol,
  output logic [RW-1:0]        botrow,
  output logic                 any_alive
);

  logic [COLS-1:0] colmask_s;
  logic [ROWS-1:0] rowmask_s;

  // Fold the mask onto columns and rows, then priority-encode both ends.
  always_comb begin
    colmask_s = '0;
    rowmask_s = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        colmask_s[c] = colmask_s[c] | alive[r*COLS+c];
        rowmask_s[r] = rowmask_s[r] | alive[r*COLS+c];
      end
    end
    leftcol  = '0;
    rightcol = '0;
    botrow   = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      leftcol = colmask_s[c] ? CW'(c) : leftcol;
    end
    for (int c = 0; c < COLS; c++) begin
      rightcol = colmask_s[c] ? CW'(c) : rightcol;
    end
    for (int r = 0; r < ROWS; r++) begin
      botrow = rowmask_s[r] ? RW'(r) : botrow;
    end
    any_alive = |colmask_s;
  end

endmodule

// File: rtl/invader_formation_ctrl.sv
// Alien formation sequencer: marches the formation on frame ticks, descends and
// reverses at screen edges, speeds up as aliens die, flags cleared / landed.
module invader_formation_ctrl
  import space_invaders_pkg::*;
#(
  parameter int COLS        = 11,
  parameter int ROWS        = 5,
  parameter int SPR_W       = 16,
  parameter int SPR_H       = 8,
  parameter int PITCH_X     = 24,
  parameter int PITCH_Y     = 16,
  parameter int STEP_X      = 4,
  parameter int STEP_Y      = 8,
  parameter int START_X     = 32,
  parameter int START_Y     = 48,
  parameter int SCREEN_W    = 640,
  parameter int LAND_Y      = 400,
  parameter int SPEED_SHIFT = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wave_start,
  input  logic                              frame_tick,
  input  logic                              kill_valid,
  input  logic [2:0]                        kill_row,
  input  logic [3:0]                        kill_col,
  output logic [X_W-1:0]                    origin_x,
  output logic [Y_W-1:0]                    origin_y,
  output logic [ROWS*COLS-1:0]              alive,
  output logic [$clog2(ROWS*COLS+1)-1:0]    alive_count,
  output logic                              anim_frame,
  output logic                              dir_left,
  output logic                              cleared,
  output logic                              landed
);

  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IW    = $clog2(N);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int EW    = 11;

  formation_state_t state_q, state_d;
  logic [X_W-1:0]   origin_x_q, origin_x_d;
  logic [Y_W-1:0]   origin_y_q, origin_y_d;
  logic [N-1:0]     alive_q, alive_d;
  logic [CNT_W-1:0] alive_count_q, alive_count_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             anim_q, anim_d;
  logic             dir_left_q, dir_left_d;

  logic [CW-1:0]    leftcol_s, rightcol_s;
  logic [RW-1:0]    botrow_s;
  logic             any_alive_s;
  logic [EW-1:0]    x_left_s, x_right_s, y_bot_s;
  logic             hit_s;
  logic [CNT_W-1:0] period_s;
  logic             kill_ok_s;
  logic [IW-1:0]    kill_idx_s;
  logic [N-1:0]     kill_mask_s;

  formation_extent #(.COLS(COLS), .ROWS(ROWS)) u_extent (
    .alive     (alive_q),
    .leftcol   (leftcol_s),
    .rightcol  (rightcol_s),
    .botrow    (botrow_s),
    .any_alive (any_alive_s)
  );

  // Edge/landing geometry, speed period and kill decode from registered state.
  always_comb begin
    x_left_s    = EW'(origin_x_q) + EW'(int'(leftcol_s) * PITCH_X);
    x_right_s   = EW'(origin_x_q) + EW'(int'(rightcol_s) * PITCH_X + SPR_W - 1 + STEP_X);
    y_bot_s     = EW'(origin_y_q) + EW'(int'(botrow_s) * PITCH_Y + SPR_H - 1);
    hit_s       = dir_left_q ? (x_left_s < EW'(STEP_X)) : (x_right_s > EW'(SCREEN_W - 1));
    period_s    = (alive_count_q >> SPEED_SHIFT) + CNT_W'(1);
    kill_ok_s   = kill_valid && (int'(kill_row) < ROWS) && (int'(kill_col) < COLS);
    kill_idx_s  = IW'(int'(kill_row) * COLS + int'(kill_col));
    kill_mask_s = kill_ok_s ? (N'(1) << kill_idx_s) : '0;
  end

  // Next-state: march/kill in MARCH, hold elsewhere, wave_start reloads from anywhere.
  always_comb begin
    state_d       = state_q;
    origin_x_d    = origin_x_q;
    origin_y_d    = origin_y_q;
    alive_d       = alive_q;
    alive_count_d = alive_count_q;
    tick_cnt_d    = tick_cnt_q;
    anim_d        = anim_q;
    dir_left_d    = dir_left_q;
    case (state_q)
      MARCH: begin
        if (!any_alive_s) begin
          state_d = CLEARED;
        end else if (y_bot_s >= EW'(LAND_Y)) begin
          state_d = LANDED;
        end else begin
          state_d = MARCH;
        end
        if ((alive_q & kill_mask_s) != '0) begin
          alive_d       = alive_q & ~kill_mask_s;
          alive_count_d = alive_count_q - CNT_W'(1);
        end else begin
          alive_d       = alive_q;
          alive_count_d = alive_count_q;
        end
        if (frame_tick && (tick_cnt_q + CNT_W'(1) >= period_s)) begin
          tick_cnt_d = '0;
          anim_d     = !anim_q;
          if (hit_s) begin
            origin_y_d = origin_y_q + Y_W'(STEP_Y);
            dir_left_d = !dir_left_q;
          end else if (dir_left_q) begin
            origin_x_d = origin_x_q - X_W'(STEP_X);
          end else begin
            origin_x_d = origin_x_q + X_W'(STEP_X);
          end
        end else if (frame_tick) begin
          tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end else begin
          tick_cnt_d = tick_cnt_q;
        end
      end
      IDLE, CLEARED, LANDED: state_d = state_q;
      default: state_d = IDLE;
    endcase
    if (wave_start) begin
      state_d       = MARCH;
      origin_x_d    = X_W'(START_X);
      origin_y_d    = Y_W'(START_Y);
      alive_d       = '1;
      alive_count_d = CNT_W'(N);
      tick_cnt_d    = '0;
      anim_d        = 1'b0;
      dir_left_d    = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // State and formation registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      origin_x_q    <= X_W'(START_X);
      origin_y_q    <= Y_W'(START_Y);
      alive_q       <= '1;
      alive_count_q <= CNT_W'(N);
      tick_cnt_q    <= '0;
      anim_q        <= 1'b0;
      dir_left_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      origin_x_q    <= origin_x_d;
      origin_y_q    <= origin_y_d;
      alive_q       <= alive_d;
      alive_count_q <= alive_count_d;
      tick_cnt_q    <= tick_cnt_d;
      anim_q        <= anim_d;
      dir_left_q    <= dir_left_d;
    end
  end

  assign origin_x    = origin_x_q;
  assign origin_y    = origin_y_q;
  assign alive       = alive_q;
  assign alive_count = alive_count_q;
  assign anim_frame  = anim_q;
  assign dir_left    = dir_left_q;
  assign cleared     = (state_q == CLEARED);
  assign landed      = (state_q == LANDED);

endmodule
